// File: rtl/irq_request_latch.sv
// Edge-capturing interrupt request latch feeding an 8:3 priority encoder.
// Synchronizes request lines, keeps sticky pending/overrun bits and offers the top request.
module irq_request_latch #(
    parameter int unsigned N       = 8,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_in,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     pend_vec,
    output logic             irq_valid,
    output logic [IDX_W-1:0] irq_idx,
    input  logic             irq_ready,
    output logic [N-1:0]     ovf,
    input  logic [N-1:0]     ovf_clr
);

    localparam int unsigned CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {IDLE, OFFER, HOLD} state_t;

    state_t           state, state_n;
    logic [N-1:0]     sync1, sync2, prev;
    logic [N-1:0]     rise, clr;
    logic [N-1:0]     pending, pending_n, ovf_n;
    logic             valid_n;
    logic [IDX_W-1:0] idx_n, top_idx;
    logic [CNT_W-1:0] cnt, cnt_n;

    assign rise     = sync2 & ~prev;
    assign pend_vec = pending & ~mask;

    always_comb begin
        top_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pend_vec[i]) top_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_n = state;
        valid_n = irq_valid;
        idx_n   = irq_idx;
        cnt_n   = cnt;
        clr     = '0;
        case (state)
            IDLE: begin
                if (|pend_vec) begin
                    valid_n = 1'b1;
                    idx_n   = top_idx;
                    state_n = OFFER;
                end
            end
            OFFER: begin
                if (irq_valid && irq_ready) begin
                    clr[irq_idx] = 1'b1;
                    valid_n      = 1'b0;
                    cnt_n        = CNT_W'(HOLDOFF - 1);
                    state_n      = HOLD;
                end
            end
            HOLD: begin
                // The last hold cycle makes the IDLE decision itself, so the
                // invalid gap between offers is exactly HOLDOFF cycles.
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (|pend_vec) begin
                    valid_n = 1'b1;
                    idx_n   = top_idx;
                    state_n = OFFER;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A new edge beats the accept clear and is not an overrun in that case.
    assign pending_n = (pending & ~clr) | rise;
    assign ovf_n     = (ovf & ~ovf_clr) | (rise & pending & ~clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            pending   <= '0;
            ovf       <= '0;
            irq_valid <= 1'b0;
            irq_idx   <= '0;
            cnt       <= '0;
            state     <= IDLE;
        end else begin
            sync1     <= req_in;
            sync2     <= sync1;
            prev      <= sync2;
            pending   <= pending_n;
            ovf       <= ovf_n;
            irq_valid <= valid_n;
            irq_idx   <= idx_n;
            cnt       <= cnt_n;
            state     <= state_n;
        end
    end

endmodule

// File: tb/tb_irq_request_latch.sv
// Scoreboard bench for irq_request_latch: directed scenarios followed by random traffic,
// checked against a sample-history / timestamp reference model.
module tb_irq_request_latch;

    localparam int HOLDOFF = 2;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic [7:0] req_in    = '0;
    logic [7:0] mask      = '0;
    logic [7:0] ovf_clr   = '0;
    logic       irq_ready = 1'b0;
    logic [7:0] pend_vec;
    logic [7:0] ovf;
    logic       irq_valid;
    logic [2:0] irq_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    // reference model state
    logic [7:0] m_pend  = '0;
    logic [7:0] m_ovf   = '0;
    logic       m_valid = 1'b0;
    int         m_idx   = 0;
    int         cyc     = 0;
    int         free_at = 0;
    logic [7:0] s0 = '0, s1 = '0, s2 = '0;

    irq_request_latch #(.N(8), .IDX_W(3), .HOLDOFF(HOLDOFF)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .pend_vec(pend_vec),
        .irq_valid(irq_valid), .irq_idx(irq_idx), .irq_ready(irq_ready),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic int highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return i;
        return 0;
    endfunction

    // Model: a line's event lands two edges after it was first sampled high
    // (sample history s0 newest). Offers are gated by an earliest-edge timestamp.
    initial begin
        logic [7:0] ev, pv, clrv;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_idx = 0;
                free_at = 0; s0 = '0; s1 = '0; s2 = '0;
                exp_q.delete();
            end else begin
                cyc++;
                ev   = s1 & ~s2;
                s2   = s1; s1 = s0; s0 = req_in;
                pv   = m_pend & ~mask;
                clrv = '0;
                if (m_valid && irq_ready) begin
                    clrv    = 8'd1 << m_idx;
                    m_valid = 1'b0;
                    free_at = cyc + HOLDOFF;
                end else if (!m_valid && cyc >= free_at && pv != 8'd0) begin
                    m_valid = 1'b1;
                    m_idx   = highest(pv);
                    exp_q.push_back(m_idx);
                end
                m_ovf  = (m_ovf & ~ovf_clr) | (ev & m_pend & ~clrv);
                m_pend = (m_pend & ~clrv) | ev;
            end
        end
    end

    // Monitor: per-cycle state checks and offer scoreboard.
    initial begin
        logic last_v;
        int   cur;
        last_v = 1'b0;
        cur    = 0;
        forever begin
            @(negedge clk);
            chk("valid", {7'd0, irq_valid}, {7'd0, m_valid});
            chk("pend_vec", pend_vec, m_pend & ~mask);
            chk("ovf", ovf, m_ovf);
            if (irq_valid && !last_v) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL offer_idx: got offer %0d expected none", irq_idx);
                end else begin
                    cur = exp_q.pop_front();
                    chk("offer_idx", {5'd0, irq_idx}, 8'(cur));
                end
            end else if (irq_valid) begin
                chk("idx_stable", {5'd0, irq_idx}, 8'(cur));
            end
            last_v = irq_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!irq_valid && n < 40);
        if (!irq_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: irq_valid timeout got 0 expected 1", nm);
        end
    endtask

    initial begin
        // T1 reset
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("t1_valid", {7'd0, irq_valid}, 8'd0);
        chk("t1_idx", {5'd0, irq_idx}, 8'd0);
        chk("t1_pend", pend_vec, 8'd0);
        chk("t1_ovf", ovf, 8'd0);

        // T2 single request
        tick(1);
        req_in = 8'h20; tick(1); req_in = '0;
        wait_valid("t2_wait");
        chk("t2_idx", {5'd0, irq_idx}, 8'd5);
        chk("t2_pend", pend_vec, 8'h20);
        irq_ready = 1'b1; @(posedge clk); #1 irq_ready = 1'b0;
        @(negedge clk);
        chk("t2_pend_clr", pend_vec, 8'h00);
        chk("t2_gap1", {7'd0, irq_valid}, 8'd0);
        @(negedge clk);
        chk("t2_gap2", {7'd0, irq_valid}, 8'd0);

        // T3 priority order with ready held high
        tick(5);
        req_in = 8'h52; tick(1); req_in = '0;
        irq_ready = 1'b1; tick(30); irq_ready = 1'b0;

        // T4 mask
        mask = 8'h80; req_in = 8'h84; tick(1); req_in = '0;
        wait_valid("t4_wait");
        chk("t4_idx", {5'd0, irq_idx}, 8'd2);
        irq_ready = 1'b1; @(posedge clk); #1 irq_ready = 1'b0;
        @(negedge clk);
        chk("t4_pend", pend_vec, 8'h00);
        tick(1);
        mask = 8'h00;
        wait_valid("t4_unmask");
        chk("t4_idx7", {5'd0, irq_idx}, 8'd7);
        irq_ready = 1'b1; tick(1); irq_ready = 1'b0;
        tick(5);

        // T5 overrun, clear, and accept/edge collision
        req_in = 8'h08; tick(1); req_in = '0;
        wait_valid("t5_wait");
        chk("t5_idx", {5'd0, irq_idx}, 8'd3);
        tick(1);
        req_in = 8'h08; tick(1); req_in = '0;
        tick(4);
        @(negedge clk);
        chk("t5_ovf_set", ovf, 8'h08);
        tick(1);
        ovf_clr = 8'h08; tick(1); ovf_clr = '0;
        @(negedge clk);
        chk("t5_ovf_clr", ovf, 8'h00);
        tick(1);
        req_in = 8'h08; tick(1); req_in = '0;
        tick(1); irq_ready = 1'b1;
        tick(1); irq_ready = 1'b0;
        @(negedge clk);
        chk("t5_coll_ovf", ovf, 8'h00);
        chk("t5_coll_pend", pend_vec, 8'h08);
        wait_valid("t5_reoffer");
        chk("t5_reidx", {5'd0, irq_idx}, 8'd3);
        irq_ready = 1'b1; tick(1); irq_ready = 1'b0;
        tick(5);

        // T6 stall then reset mid-offer
        req_in = 8'h01; tick(1); req_in = '0;
        wait_valid("t6_wait");
        repeat (10) begin
            @(negedge clk);
            chk("t6_stall_idx", {5'd0, irq_idx}, 8'd0);
            chk("t6_stall_valid", {7'd0, irq_valid}, 8'd1);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_async_valid", {7'd0, irq_valid}, 8'd0);
        chk("t6_async_pend", pend_vec, 8'd0);
        tick(2);
        rst = 1'b0;

        // random traffic
        for (int i = 0; i < 800; i++) begin
            tick(1);
            req_in    = 8'($urandom & $urandom);
            if ($urandom_range(0, 7) == 0) mask = 8'($urandom & $urandom);
            irq_ready = ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'd0;
            rst       = ($urandom_range(0, 199) == 0);
        end
        tick(1);
        rst = 1'b0; req_in = '0; ovf_clr = '0; irq_ready = 1'b0;
        tick(10);
        @(negedge clk);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
